// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths and the fetch-queue entry type for the CPU front end.
//   WORD_W     - instruction and PC width
//   IM_AW      - instruction-memory word-address width
//   fq_entry_t - one queued instruction together with its word PC
package cpu_pkg;
   localparam int WORD_W = 32;
   localparam int IM_AW  = 8;

   typedef struct packed {
      logic [WORD_W-1:0] ins;
      logic [WORD_W-1:0] pc;
   } fq_entry_t;
endpackage

// File: rtl/fq_ring.sv
// fq_ring: DEPTH-entry ring buffer holding fetched instructions with their PCs.
//   clk, rstd  - clock, asynchronous active-low reset
//   push       - write push_data at the tail (ignored when full)
//   pop        - drop the head entry (ignored when empty)
//   flush      - empty the ring; has priority over push and pop
//   head       - entry at the read pointer (registered storage)
//   full/empty - occupancy flags; count - number of stored entries
module fq_ring
   import cpu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rstd,
   input  logic                   push,
   input  fq_entry_t              push_data,
   input  logic                   pop,
   input  logic                   flush,
   output fq_entry_t              head,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int PW = $clog2(DEPTH);

   logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [PW:0]   count_q, count_d;
   logic          do_push, do_pop;
   fq_entry_t     mem_q [DEPTH];

   always_comb begin
      do_push  = push && !full;
      do_pop   = pop && !empty;
      // DEPTH is a power of two, so pointer overflow is the modulo wrap
      rd_ptr_d = flush ? '0 : do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      wr_ptr_d = flush ? '0 : do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      count_d  = flush ? '0 : count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
   end

   always_ff @(posedge clk or negedge rstd) begin
      if (!rstd) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
   end

   assign head  = mem_q[rd_ptr_q];
   assign empty = count_q == '0;
   assign full  = count_q == (PW+1)'(DEPTH);
   assign count = count_q;
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch stage with a small instruction/PC queue feeding execute.
//   clk, rstd            - clock, asynchronous active-low reset
//   im_req, im_addr      - read strobe and word address to the 1-cycle-latency instruction memory
//   im_rdata             - read data, valid the cycle after an accepted im_req
//   ins, ins_pc          - head instruction and its word PC
//   ins_valid, ins_ready - head handshake with execute
//   redirect, redirect_pc - flush everything and refetch from redirect_pc
//   flush_count, stall_count - saturating statistics, present only with FETCH_QUEUE_STATS_EN
module fetch_queue
   import cpu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = IM_AW
) (
   input  logic              clk,
   input  logic              rstd,
   output logic              im_req,
   output logic [AW-1:0]     im_addr,
   input  logic [WORD_W-1:0] im_rdata,
   output logic [WORD_W-1:0] ins,
   output logic [WORD_W-1:0] ins_pc,
   output logic              ins_valid,
   input  logic              ins_ready,
   input  logic              redirect,
   input  logic [WORD_W-1:0] redirect_pc
`ifdef FETCH_QUEUE_STATS_EN
   ,
   output logic [15:0]       flush_count,
   output logic [15:0]       stall_count
`endif
);
   logic [WORD_W-1:0]      fetch_pc_q, fetch_pc_d, inflight_pc_q, inflight_pc_d;
   logic                   inflight_q, inflight_d;
   logic                   credit, push, pop, full, empty;
   logic [$clog2(DEPTH):0] count;
   fq_entry_t              head;

   fq_ring #(.DEPTH(DEPTH)) u_ring (
      .clk       (clk),
      .rstd      (rstd),
      .push      (push),
      .push_data ('{ins: im_rdata, pc: inflight_pc_q}),
      .pop       (pop),
      .flush     (redirect),
      .head      (head),
      .full      (full),
      .empty     (empty),
      .count     (count)
   );

   always_comb begin
      // counting the in-flight read reserves its slot, so a push never finds the ring full
      credit        = !full && (int'(count) + int'(inflight_q)) < DEPTH;
      // rstd gating keeps the strobe quiet while the async reset is held
      im_req        = rstd && credit && !redirect;
      push          = inflight_q && !redirect;
      pop           = !empty && ins_ready;
      fetch_pc_d    = redirect ? redirect_pc : im_req ? fetch_pc_q + 1'b1 : fetch_pc_q;
      inflight_d    = im_req;
      inflight_pc_d = im_req ? fetch_pc_q : inflight_pc_q;
   end

   always_ff @(posedge clk or negedge rstd) begin
      if (!rstd) begin
         fetch_pc_q    <= '0;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
      end
   end

   assign im_addr   = fetch_pc_q[AW-1:0];
   assign ins       = head.ins;
   assign ins_pc    = head.pc;
   assign ins_valid = !empty;

`ifdef FETCH_QUEUE_STATS_EN
   logic [15:0] flush_count_q, flush_count_d, stall_count_q, stall_count_d;

   always_comb begin
      flush_count_d = (redirect && flush_count_q != 16'hFFFF) ? flush_count_q + 16'd1 : flush_count_q;
      stall_count_d = (!ins_valid && stall_count_q != 16'hFFFF) ? stall_count_q + 16'd1 : stall_count_q;
   end

   always_ff @(posedge clk or negedge rstd) begin
      if (!rstd) begin
         flush_count_q <= '0;
         stall_count_q <= '0;
      end else begin
         flush_count_q <= flush_count_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign flush_count = flush_count_q;
   assign stall_count = stall_count_q;
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized scoreboard bench for fetch_queue (FETCH_QUEUE_STATS_EN optional).
module tb_fetch_queue;
   localparam int DEPTH = 4;

   logic        clk, rstd, im_req, ins_valid, ins_ready, redirect;
   logic [7:0]  im_addr;
   logic [31:0] im_rdata, ins, ins_pc, redirect_pc;
`ifdef FETCH_QUEUE_STATS_EN
   logic [15:0] flush_count, stall_count;
`endif

   fetch_queue #(.DEPTH(DEPTH), .AW(8)) dut (
      .clk         (clk),
      .rstd        (rstd),
      .im_req      (im_req),
      .im_addr     (im_addr),
      .im_rdata    (im_rdata),
      .ins         (ins),
      .ins_pc      (ins_pc),
      .ins_valid   (ins_valid),
      .ins_ready   (ins_ready),
      .redirect    (redirect),
      .redirect_pc (redirect_pc)
`ifdef FETCH_QUEUE_STATS_EN
      ,
      .flush_count (flush_count),
      .stall_count (stall_count)
`endif
   );

   int total = 0, bad = 0;
   int iss = 0, pops = 0, stall_exp = 0, flush_exp = 0;
   logic [31:0] exp_fetch = 0;
   logic [31:0] sb[$];
   logic [31:0] sb_next;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] memf(logic [7:0] a);
      return 32'(a) * 32'h11;
   endfunction

   // memory model: one-cycle latency, garbage when not read
   always @(posedge clk) im_rdata <= im_req ? memf(im_addr) : $urandom;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic sb_top();
      while (sb.size() < 16) begin
         sb.push_back(sb_next);
         sb_next++;
      end
   endtask

   task automatic sb_restart(logic [31:0] pc);
      sb.delete();
      sb_next = pc;
      sb_top();
   endtask

   // monitor: outstanding = issued - popped since last flush must stay below DEPTH
   always @(negedge clk) begin
      logic pop;
      logic [31:0] f;
      if (!rstd) begin
         iss = 0; pops = 0; exp_fetch = 0; stall_exp = 0; flush_exp = 0;
      end else begin
         chk("im_req", {31'b0, im_req}, {31'b0, !redirect && (iss - pops) < DEPTH});
         if (im_req) chk("im_addr", {24'b0, im_addr}, {24'b0, exp_fetch[7:0]});
         pop = ins_valid && ins_ready;
         if (!ins_valid) stall_exp++;
         if (pop) begin
            if (sb.size() == 0) begin
               total++; bad++;
               $display("FAIL pop_unexpected: got pc %h expected none", ins_pc);
            end else begin
               f = sb.pop_front();
               chk("ins_pc", ins_pc, f);
               chk("ins", ins, memf(f[7:0]));
            end
         end
         if (redirect) begin
            iss = 0; pops = 0; exp_fetch = redirect_pc; flush_exp++;
         end else begin
            if (im_req) begin iss++; exp_fetch++; end
            if (pop) pops++;
         end
      end
   end

   task automatic step();
      @(posedge clk); #1;
      sb_top();
   endtask

   task automatic do_reset();
      #2 rstd = 1'b0;
      #1;
      chk("rst_im_req", {31'b0, im_req}, 32'd0);
      chk("rst_valid", {31'b0, ins_valid}, 32'd0);
      @(posedge clk); #1;
      rstd = 1'b1;
      sb_restart(32'd0);
   endtask

   task automatic check_restart();
      @(negedge clk) chk("lat0_valid", {31'b0, ins_valid}, 32'd0);
      chk("lat0_addr", {24'b0, im_addr}, 32'd0);
      step();
      @(negedge clk) chk("lat1_valid", {31'b0, ins_valid}, 32'd0);
      step();
      @(negedge clk) chk("lat2_valid", {31'b0, ins_valid}, 32'd1);
      chk("lat2_pc", ins_pc, 32'd0);
      step();
   endtask

   task automatic do_redirect(logic [31:0] pc);
      redirect = 1'b1;
      redirect_pc = pc;
      @(posedge clk); #1;
      redirect = 1'b0;
      sb_restart(pc);
      @(negedge clk) chk("redir_gap0", {31'b0, ins_valid}, 32'd0);
      step();
      @(negedge clk) chk("redir_gap1", {31'b0, ins_valid}, 32'd0);
      step();
      @(negedge clk) chk("redir_valid", {31'b0, ins_valid}, 32'd1);
      chk("redir_pc", ins_pc, pc);
      step();
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int n;
      rstd = 1'b0; ins_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
      sb_restart(32'd0);
      #1;
      chk("rst_im_req", {31'b0, im_req}, 32'd0);
      chk("rst_valid", {31'b0, ins_valid}, 32'd0);
      @(posedge clk); #1;
      rstd = 1'b1;
      ins_ready = 1'b1;
      check_restart();
      n = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk) n += int'(ins_valid);
         step();
      end
      chk("throughput", n, 20);
      ins_ready = 1'b0;
      for (int i = 0; i < 10; i++) step();
      @(negedge clk) chk("full_im_req", {31'b0, im_req}, 32'd0);
      chk("full_valid", {31'b0, ins_valid}, 32'd1);
      step();
      ins_ready = 1'b1;
      n = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk) n += int'(ins_valid);
         step();
      end
      chk("drain_no_gap", n, 8);
      ins_ready = 1'b0;
      for (int i = 0; i < 3; i++) step();
      do_redirect(32'h40);
      ins_ready = 1'b1;
      for (int i = 0; i < 5; i++) step();
      do_redirect(32'h100);
      for (int i = 0; i < 5; i++) step();
      do_reset();
      check_restart();
      for (int i = 0; i < 1500; i++) begin
         ins_ready = ($urandom % 4) != 0;
         if ($urandom % 400 == 0) begin
            do_reset();
            check_restart();
         end else if ($urandom % 20 == 0)
            do_redirect(($urandom % 2) ? 32'hFFFF_FFFE : $urandom);
         else
            step();
      end
      ins_ready = 1'b1;
      do_reset();
      check_restart();
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 4; j++) step();
         do_redirect($urandom);
      end
      step();
`ifdef FETCH_QUEUE_STATS_EN
      chk("flush_count", {16'b0, flush_count}, 32'd3);
      chk("flush_model", {16'b0, flush_count}, 32'(flush_exp));
      chk("stall_count", {16'b0, stall_count}, 32'(stall_exp));
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
